// File: rtl/mem_arbiter.sv
// Two-port fixed-priority arbiter in front of a single-port 32-bit BRAM.
// Port 0 wins contention except when port 1 has waited STARVE_LIMIT cycles.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_valid,
  input  logic                  m0_write,
  input  logic [3:0]            m0_wmask,
  input  logic [31:0]           m0_wdata,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  output logic                  m0_ready,
  output logic                  m0_rvalid,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_valid,
  input  logic                  m1_write,
  input  logic [3:0]            m1_wmask,
  input  logic [31:0]           m1_wdata,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  output logic                  m1_ready,
  output logic                  m1_rvalid,
  output logic [31:0]           m1_rdata,
  output logic                  mem_write,
  output logic [3:0]            mem_wmask,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [1:0]       rv_q, rv_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             promote, g0, g1;

  always_comb begin
    promote = (STARVE_LIMIT != 0) && (starve_cnt_q >= LIMIT);
    g1      = m1_valid && (!m0_valid || promote);
    g0      = m0_valid && !g1;

    // Idle cycles present port 0's fields; only mem_write must be quiet then.
    if (g1) begin
      mem_wmask = m1_wmask;
      mem_wdata = m1_wdata;
      mem_addr  = m1_addr;
    end else begin
      mem_wmask = m0_wmask;
      mem_wdata = m0_wdata;
      mem_addr  = m0_addr;
    end
    mem_write = (g0 && m0_write) || (g1 && m1_write);

    rv_d = {g1 && !m1_write, g0 && !m0_write};

    // Saturating wait counter; with no limit it saturates at zero.
    if (m1_valid && !g1) begin
      if (starve_cnt_q >= LIMIT) begin
        starve_cnt_d = LIMIT;
      end else begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end else begin
      starve_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rv_q         <= '0;
      starve_cnt_q <= '0;
    end else begin
      rv_q         <= rv_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign m0_ready  = g0;
  assign m1_ready  = g1;
  // Gated by rst so a read in flight when reset arrives is dropped immediately.
  assign m0_rvalid = rv_q[0] && !rst;
  assign m1_rvalid = rv_q[1] && !rst;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a STARVE_LIMIT=4 instance with a BRAM model
// and a STARVE_LIMIT=0 instance, both checked against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;
  localparam int LIM_A = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          m0_valid, m0_write, m1_valid, m1_write;
  logic [3:0]    m0_wmask, m1_wmask;
  logic [31:0]   m0_wdata, m1_wdata;
  logic [AW-1:0] m0_addr, m1_addr;

  logic          a_m0_ready, a_m0_rvalid, a_m1_ready, a_m1_rvalid, a_mem_write;
  logic [31:0]   a_m0_rdata, a_m1_rdata, a_mem_wdata, a_mem_rdata;
  logic [3:0]    a_mem_wmask;
  logic [AW-1:0] a_mem_addr;

  logic          b_m0_ready, b_m0_rvalid, b_m1_ready, b_m1_rvalid, b_mem_write;
  logic [31:0]   b_m0_rdata, b_m1_rdata, b_mem_wdata;
  logic [31:0]   b_mem_rdata = 32'h0;
  logic [3:0]    b_mem_wmask;
  logic [AW-1:0] b_mem_addr;

  mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIM_A)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_write(m0_write), .m0_wmask(m0_wmask), .m0_wdata(m0_wdata),
    .m0_addr(m0_addr), .m0_ready(a_m0_ready), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
    .m1_valid(m1_valid), .m1_write(m1_write), .m1_wmask(m1_wmask), .m1_wdata(m1_wdata),
    .m1_addr(m1_addr), .m1_ready(a_m1_ready), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
    .mem_write(a_mem_write), .mem_wmask(a_mem_wmask), .mem_wdata(a_mem_wdata),
    .mem_addr(a_mem_addr), .mem_rdata(a_mem_rdata)
  );

  mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(0)) dut_strict (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_write(m0_write), .m0_wmask(m0_wmask), .m0_wdata(m0_wdata),
    .m0_addr(m0_addr), .m0_ready(b_m0_ready), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_valid(m1_valid), .m1_write(m1_write), .m1_wmask(m1_wmask), .m1_wdata(m1_wdata),
    .m1_addr(m1_addr), .m1_ready(b_m1_ready), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .mem_write(b_mem_write), .mem_wmask(b_mem_wmask), .mem_wdata(b_mem_wdata),
    .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata)
  );

  // BRAM behind the limited instance: byte-masked write, one-cycle registered read.
  logic [31:0] bram   [DEPTH];
  logic [31:0] shadow [DEPTH];

  always @(posedge clk) begin
    if (a_mem_write) begin
      for (int b = 0; b < 4; b++)
        if (a_mem_wmask[b]) bram[a_mem_addr][8*b +: 8] <= a_mem_wdata[8*b +: 8];
    end
    a_mem_rdata <= bram[a_mem_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Pending requests as the requesters see them.
  logic          act0, act1, w0, w1;
  logic [3:0]    k0, k1;
  logic [31:0]   d0, d1;
  logic [AW-1:0] ad0, ad1;

  // Reference state: how long port 1 has waited, and reads owed next cycle.
  int          wait_a, wait_b;
  logic        exp_rv0_a, exp_rv1_a, exp_rv0_b, exp_rv1_b;
  logic [31:0] exp_rdata;
  int          cyc = 0;

  task automatic apply();
    m0_valid = act0 && !rst; m0_write = w0; m0_wmask = k0; m0_wdata = d0; m0_addr = ad0;
    m1_valid = act1 && !rst; m1_write = w1; m1_wmask = k1; m1_wdata = d1; m1_addr = ad1;
  endtask

  task automatic gen(input int p0, input int p1);
    if (!act0 && !rst && $urandom_range(99) < p0) begin
      act0 = 1'b1; w0 = $urandom_range(3) == 0; k0 = 4'($urandom_range(15));
      d0 = $urandom; ad0 = AW'($urandom_range(63));
    end
    if (!act1 && !rst && $urandom_range(99) < p1) begin
      act1 = 1'b1; w1 = $urandom_range(1) == 0; k1 = 4'($urandom_range(15));
      d1 = $urandom; ad1 = AW'($urandom_range(63));
    end
    apply();
  endtask

  task automatic req(input int port, input logic wr, input logic [3:0] mask,
                     input logic [31:0] data, input logic [AW-1:0] addr);
    if (port == 0) begin act0 = 1'b1; w0 = wr; k0 = mask; d0 = data; ad0 = addr; end
    else begin act1 = 1'b1; w1 = wr; k1 = mask; d1 = data; ad1 = addr; end
    apply();
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] mask);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // One clock cycle: judge everything at the falling edge, then advance the model.
  task automatic step();
    logic v0, v1, ga0, ga1, gb0, gb1;
    @(negedge clk);
    cyc++;
    v0 = m0_valid; v1 = m1_valid;
    ga1 = v1 && (!v0 || wait_a >= LIM_A);
    ga0 = v0 && !ga1;
    gb1 = v1 && !v0;
    gb0 = v0;

    chk("a_m0_ready", 32'(a_m0_ready), 32'(ga0));
    chk("a_m1_ready", 32'(a_m1_ready), 32'(ga1));
    chk("b_m0_ready", 32'(b_m0_ready), 32'(gb0));
    chk("b_m1_ready", 32'(b_m1_ready), 32'(gb1));
    chk("a_m0_rvalid", 32'(a_m0_rvalid), 32'(exp_rv0_a && !rst));
    chk("a_m1_rvalid", 32'(a_m1_rvalid), 32'(exp_rv1_a && !rst));
    chk("b_m0_rvalid", 32'(b_m0_rvalid), 32'(exp_rv0_b && !rst));
    chk("b_m1_rvalid", 32'(b_m1_rvalid), 32'(exp_rv1_b && !rst));
    if (!rst && exp_rv0_a) chk("a_m0_rdata", a_m0_rdata, exp_rdata);
    if (!rst && exp_rv1_a) chk("a_m1_rdata", a_m1_rdata, exp_rdata);
    chk("a_mem_write", 32'(a_mem_write), 32'((ga0 && w0) || (ga1 && w1)));
    if (ga0 || ga1) chk("a_mem_addr", 32'(a_mem_addr), 32'(ga1 ? ad1 : ad0));
    if ((ga0 && w0) || (ga1 && w1)) begin
      chk("a_mem_wdata", a_mem_wdata, ga1 ? d1 : d0);
      chk("a_mem_wmask", 32'(a_mem_wmask), 32'(ga1 ? k1 : k0));
    end

    if (ga0 || ga1)
      $display("cyc %0d port%0d %s addr=%h data=%h mask=%b", cyc, ga1 ? 1 : 0,
               (ga1 ? w1 : w0) ? "write" : "read ", ga1 ? ad1 : ad0,
               ga1 ? d1 : d0, ga1 ? k1 : k0);

    exp_rv0_a = !rst && ga0 && !w0;
    exp_rv1_a = !rst && ga1 && !w1;
    exp_rv0_b = !rst && gb0 && !w0;
    exp_rv1_b = !rst && gb1 && !w1;
    if (ga0 && !w0) exp_rdata = shadow[ad0];
    if (ga1 && !w1) exp_rdata = shadow[ad1];
    if (ga0 && w0) shadow[ad0] = merge(shadow[ad0], d0, k0);
    if (ga1 && w1) shadow[ad1] = merge(shadow[ad1], d1, k1);
    wait_a = rst ? 0 : (v1 && !ga1) ? ((wait_a + 1 > LIM_A) ? LIM_A : wait_a + 1) : 0;
    wait_b = 0;
    if (ga0) act0 = 1'b0;
    if (ga1) act1 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pre;
    for (int i = 0; i < DEPTH; i++) begin
      bram[i]   = (i * 32'h9E3779B1) ^ 32'h5A5A_0000;
      shadow[i] = (i * 32'h9E3779B1) ^ 32'h5A5A_0000;
    end
    act0 = 0; act1 = 0; w0 = 0; w1 = 0; k0 = 0; k1 = 0; d0 = 0; d1 = 0; ad0 = 0; ad1 = 0;
    wait_a = 0; wait_b = 0; exp_rdata = 0;
    exp_rv0_a = 0; exp_rv1_a = 0; exp_rv0_b = 0; exp_rv1_b = 0;
    rst = 1'b1;
    apply();
    @(posedge clk); #1;
    repeat (2) step();
    rst = 1'b0;
    apply();

    // Lone port-0 read of 0x10.
    req(0, 1'b0, 4'h0, 32'h0, AW'(16'h10));
    step();
    apply();
    step();

    // Continuous contention: port 1 forced through every fifth cycle.
    for (int i = 0; i < 12; i++) begin gen(100, 100); step(); end
    act0 = 0; act1 = 0; apply(); step();

    // Partial write from port 1, then read back from port 0.
    pre = shadow[16'h20];
    req(1, 1'b1, 4'b0011, 32'hDEADBEEF, AW'(16'h20));
    step();
    req(0, 1'b0, 4'h0, 32'h0, AW'(16'h20));
    step();
    apply();
    step();
    chk("merge_0x20", shadow[16'h20], {pre[31:16], 16'hBEEF});

    // Alternating single reads.
    for (int i = 0; i < 8; i++) begin
      req(i % 2, 1'b0, 4'h0, 32'h0, AW'(i));
      step();
    end
    apply(); step();

    // Reset lands on the cycle after a port-1 read grant.
    req(1, 1'b0, 4'h0, 32'h0, AW'(16'h30));
    step();
    rst = 1'b1; apply(); step();
    rst = 1'b0; apply();
    for (int i = 0; i < 8; i++) begin gen(100, 100); step(); end

    // Long contention: the strict instance must never grant port 1.
    for (int i = 0; i < 100; i++) begin gen(100, 100); step(); end

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) begin
        rst = 1'b1; apply(); step();
        rst = 1'b0;
      end
      gen($urandom_range(100), $urandom_range(100));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
